// File: rtl/down_counter_if.sv
// Control/status bundle for the programmable countdown timer.
// The master drives load/clear/enable controls; the timer (slave) returns count and events.
interface down_counter_if #(
    parameter int WIDTH = 8
);
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] v;
    logic             en;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             busy;
    logic             done;

    modport master (
        output clr, load, v, en, auto_reload,
        input  count, tc, busy, done
    );

    modport slave (
        input  clr, load, v, en, auto_reload,
        output count, tc, busy, done
    );
endinterface

// File: rtl/down_counter.sv
// Programmable countdown timer: counts a loaded value down to zero, pulses tc on expiry,
// then either stops (one-shot, DONE) or reloads from the reload register (periodic).
module down_counter #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    down_counter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] reload_q;
    logic             tc_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] count_dec_d;
    logic             expire_d;

    assign count_dec_d = count_q - ONE;
    assign expire_d    = (state_q == RUN) && bus.en && (count_q == ONE);

    // Priority per edge: clr, then load, then counting/expiry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            count_q  <= ZERO;
            reload_q <= ZERO;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            if (bus.clr) begin
                state_q <= IDLE;
                count_q <= ZERO;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else if (bus.load) begin
                count_q  <= bus.v;
                reload_q <= bus.v;
                done_q   <= 1'b0;
                // A zero load parks in IDLE so it can never produce a tc.
                if (bus.v != ZERO) begin
                    state_q <= RUN;
                    busy_q  <= 1'b1;
                end else begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            end else begin
                case (state_q)
                    RUN: begin
                        if (expire_d) begin
                            tc_q <= 1'b1;
                            if (bus.auto_reload) begin
                                count_q <= reload_q;
                            end else begin
                                count_q <= ZERO;
                                state_q <= DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else if (bus.en && (count_q > ONE)) begin
                            count_q <= count_dec_d;
                        end
                    end
                    DONE: begin
                        count_q <= ZERO;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule
